uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 5208, giving clock cycles per serial bit (50 MHz / 9600 baud).
REQ-002 The module SHALL have parameter STOP_BITS, default 1, giving the number of stop bits per frame (legal values 1 or 2).
REQ-003 The module SHALL have port clock, input, 1 bit: the single system clock; all logic is on the rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port instrucao, input, 4 bits: instruction nibble to transmit.
REQ-006 The module SHALL have port dado, input, 4 bits: data nibble to transmit.
REQ-007 The module SHALL have port start, input, 1 bit: request to send; sampled only when ready is 1.
REQ-008 The module SHALL have port ready, output, 1 bit: 1 when a request can be accepted.
REQ-009 The module SHALL have port out, output, 1 bit: serial line, idle high.
REQ-010 The module SHALL have port done, output, 1 bit: one-cycle pulse at the end of the last stop bit.

Function
REQ-011 Transmitted byte SHALL be {instrucao, dado}: dado in bits 3:0, instrucao in bits 7:4; both captured in the cycle start is accepted.
REQ-012 Frame SHALL be: 1 start bit (0), 8 data bits LSB first, then STOP_BITS stop bits (1), with no parity bit.
REQ-013 Each bit SHALL be held on out for exactly CLKS_PER_BIT clock cycles.
REQ-014 The state machine SHALL have states IDLE, START, DATA, STOP; no other states are reachable.
REQ-015 IDLE: out=1 and ready=1; start=1 SHALL go to START on the next edge.
REQ-016 START SHALL drive out=0 for one bit time, then go to DATA.
REQ-017 DATA SHALL shift out 8 bits using a 3-bit bit index that counts from 0 to 7, then go to STOP.
REQ-018 STOP SHALL drive out=1 for STOP_BITS bit times, then go to IDLE.
REQ-019 done SHALL pulse for 1 cycle in the cycle that STOP exits; ready SHALL rise in the same cycle.
REQ-020 Latency SHALL be exactly 1 cycle from the start-accept edge to the first cycle of out=0.
REQ-021 Total frame length SHALL be (9+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-022 The start bit of a new frame SHALL begin within 1 cycle after done when start is held high (back-to-back frames).
REQ-023 ready SHALL be 0 in START, DATA and STOP; start asserted while ready=0 SHALL be ignored and not queued.
REQ-024 Changes on instrucao or dado after acceptance SHALL NOT affect the frame in flight.
REQ-025 The baud counter SHALL count 0..CLKS_PER_BIT-1, reset to 0 on every bit boundary, and not exceed its width of clog2(CLKS_PER_BIT) bits.
REQ-026 out SHALL be driven from a register, with no combinational path from inputs to out.

Reset
REQ-027 Asserting reset SHALL immediately force: state IDLE, out=1, ready=1, done=0, baud counter 0, bit index 0, shift register 0.
REQ-028 Reset mid-frame SHALL abort the frame with the line returned high, and SHALL NOT pulse done.
REQ-029 On the first edge after reset is released, the module SHALL be able to accept start.

Structure
REQ-030 The shared package uart_pkg SHALL hold the state encodings (IDLE/START/DATA/STOP) and the frame constants (DATA_BITS=8, start level 0, idle and stop level 1); the rx-side uart SHALL reuse this package.
REQ-031 Bit timing SHALL live in one sub-module, baud_gen (inputs clock, reset, enable; output tick once per CLKS_PER_BIT cycles, restarting when enable rises).

Verification (CLKS_PER_BIT=4, STOP_BITS=1 unless noted)
REQ-032 Scenario: instrucao=4'hA, dado=4'h5, start pulse -> out shows 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; done pulses at cycle 40; ready returns to 1.
REQ-033 Scenario: start held high with two values, 8'h3C then 8'hF0 -> two contiguous 40-cycle frames, no idle gap longer than 1 cycle, two done pulses.
REQ-034 Scenario: start pulsed during DATA of a frame -> ignored; exactly one frame on out and one done pulse.
REQ-035 Scenario: reset asserted at cycle 17 of a frame -> out=1 and ready=1 asynchronously, no done pulse; next start yields a correct full frame.
REQ-036 Scenario: inputs changed to 8'h00 after acceptance of 8'hFF -> the line still carries eight 1 data bits.
REQ-037 Scenario: STOP_BITS=2 with 8'h81 -> frame is 44 cycles with a stop high for 8 cycles; loopback into the rx-side uart yields instruction 4'h8 and data 4'h1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, frame levels and byte packing.
// Used by both the transmitter and the receive-side UART.
package uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic STOP_LEVEL  = 1'b1;

  typedef logic [DATA_BITS-1:0] uart_byte_t;

  // The instruction nibble occupies the upper half of the transmitted byte.
  function automatic uart_byte_t pack_byte(input logic [3:0] instr,
                                           input logic [3:0] data);
    return {instr, data};
  endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-time generator: one tick every CLKS_PER_BIT cycles while enabled.
// The counter is held at zero while disabled, so timing restarts cleanly
// each time enable rises.
module baud_gen #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = enable && (cnt == CNT_MAX);

  // Count within a bit time; wrap to zero on every bit boundary.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!enable || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: sends {instrucao, dado} as 1 start bit, 8 data bits
// LSB first and STOP_BITS stop bits, no parity. The serial line is a
// register so nothing combinational reaches the pin.
module uart_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int STOP_BITS    = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] instrucao,
  input  logic [3:0] dado,
  input  logic       start,
  output logic       ready,
  output logic       out,
  output logic       done
);

  import uart_pkg::*;

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  logic [1:0]  state;
  uart_byte_t  shreg;
  logic [2:0]  bit_idx;
  logic        stop_cnt;
  logic        tick;

  // Bit timing runs only while a frame is in flight.
  baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clock  (clock),
    .reset  (reset),
    .enable (state != ST_IDLE),
    .tick   (tick)
  );

  assign ready = (state == ST_IDLE);

  // Frame sequencer: the line level for the next bit is loaded on the
  // same edge that changes state, giving one cycle from accept to start bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      out      <= IDLE_LEVEL;
      done     <= 1'b0;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          out <= IDLE_LEVEL;
          if (start) begin
            shreg    <= pack_byte(instrucao, dado);
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            out      <= START_LEVEL;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            out     <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx == LAST_BIT) begin
              out   <= STOP_LEVEL;
              state <= ST_STOP;
            end else begin
              out     <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (stop_cnt == STOP_LAST) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: two instances (one and two stop bits), checked
// cycle by cycle against a line-level model of the UART frame.
module tb_uart_tx;

  localparam int CPB = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] instrucao, dado, instrucao2, dado2;
  logic       start, start2;
  logic       ready, out, done;
  logic       ready2, out2, done2;

  int tests  = 0;
  int failed = 0;

  always #5 clock = ~clock;

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clock(clock), .reset(reset), .instrucao(instrucao), .dado(dado),
    .start(start), .ready(ready), .out(out), .done(done)
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clock(clock), .reset(reset), .instrucao(instrucao2), .dado(dado2),
    .start(start2), .ready(ready2), .out(out2), .done(done2)
  );

  // Expected line level idx cycles after the first start-bit cycle:
  // slot 0 is the start bit, slots 1..8 the data LSB first, then high.
  function automatic logic model_bit(input logic [7:0] b, input int idx);
    int slot;
    slot = idx / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    return 1'b1;
  endfunction

  // Present a byte with a one-cycle start pulse; returns at the negedge
  // of the first start-bit cycle.
  task automatic launch(input logic [7:0] b);
    @(negedge clock);
    instrucao = b[7:4]; dado = b[3:0]; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    instrucao = 4'h0; dado = 4'h0; instrucao2 = 4'h0; dado2 = 4'h0;
    #2;
    tests++; if (out    !== 1'b1) begin failed++; $display("FAIL reset_out: got %b want 1", out); end
    tests++; if (ready  !== 1'b1) begin failed++; $display("FAIL reset_ready: got %b want 1", ready); end
    tests++; if (done   !== 1'b0) begin failed++; $display("FAIL reset_done: got %b want 0", done); end
    tests++; if (out2   !== 1'b1) begin failed++; $display("FAIL reset_out2: got %b want 1", out2); end
    tests++; if (ready2 !== 1'b1) begin failed++; $display("FAIL reset_ready2: got %b want 1", ready2); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_basic_frame();
    logic [7:0] b;
    logic [9:0] exp_a5;
    exp_a5 = 10'b1101001010;  // bit i = level of frame bit i: 0,1,0,1,0,0,1,0,1,1
    for (int n = 0; n < 5; n++) begin
      b = (n == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      launch(b);
      for (int i = 0; i < 40; i++) begin
        tests++; if (out !== model_bit(b, i)) begin failed++; $display("FAIL frame_out b=%h cyc=%0d: got %b want %b", b, i, out, model_bit(b, i)); end
        tests++; if (ready !== 1'b0) begin failed++; $display("FAIL frame_ready b=%h cyc=%0d: got %b want 0", b, i, ready); end
        tests++; if (done !== 1'b0) begin failed++; $display("FAIL frame_done_early b=%h cyc=%0d: got %b want 0", b, i, done); end
        if (n == 0 && (i % CPB) == 2) begin
          tests++; if (out !== exp_a5[i/CPB]) begin failed++; $display("FAIL a5_bit%0d: got %b want %b", i/CPB, out, exp_a5[i/CPB]); end
        end
        @(negedge clock);
      end
      tests++; if (done  !== 1'b1) begin failed++; $display("FAIL frame_done b=%h: got %b want 1", b, done); end
      tests++; if (ready !== 1'b1) begin failed++; $display("FAIL frame_ready_end b=%h: got %b want 1", b, ready); end
      tests++; if (out   !== 1'b1) begin failed++; $display("FAIL frame_idle b=%h: got %b want 1", b, out); end
      @(negedge clock);
      tests++; if (done  !== 1'b0) begin failed++; $display("FAIL frame_done_width b=%h: got %b want 0", b, done); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b1, b2;
    logic       e;
    int         pulses;
    b1 = 8'h3C; b2 = 8'hF0; pulses = 0;
    @(negedge clock);
    instrucao = b1[7:4]; dado = b1[3:0]; start = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 82; i++) begin
      if (done === 1'b1) pulses++;
      if (i < 40)       e = model_bit(b1, i);
      else if (i == 40) e = 1'b1;
      else if (i < 81)  e = model_bit(b2, i - 41);
      else              e = 1'b1;
      tests++; if (out !== e) begin failed++; $display("FAIL b2b_out cyc=%0d: got %b want %b", i, out, e); end
      if (i == 40 || i == 81) begin
        tests++; if (done !== 1'b1) begin failed++; $display("FAIL b2b_done cyc=%0d: got %b want 1", i, done); end
        tests++; if (ready !== 1'b1) begin failed++; $display("FAIL b2b_ready cyc=%0d: got %b want 1", i, ready); end
      end
      if (i == 10) begin instrucao = b2[7:4]; dado = b2[3:0]; end
      if (i == 81) start = 1'b0;
      @(negedge clock);
    end
    tests++; if (pulses !== 2) begin failed++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
    tests++; if (out !== 1'b1 || ready !== 1'b1) begin failed++; $display("FAIL b2b_idle: got out=%b ready=%b want 1 1", out, ready); end
  endtask

  task automatic test_ignore_start();
    logic [7:0] b;
    logic       e;
    int         pulses;
    b = 8'($urandom_range(0, 255)); pulses = 0;
    launch(b);
    for (int i = 0; i < 61; i++) begin
      if (done === 1'b1) pulses++;
      e = (i < 40) ? model_bit(b, i) : 1'b1;
      tests++; if (out !== e) begin failed++; $display("FAIL ign_out cyc=%0d: got %b want %b", i, out, e); end
      if (i > 40) begin
        tests++; if (ready !== 1'b1) begin failed++; $display("FAIL ign_ready cyc=%0d: got %b want 1", i, ready); end
      end
      if (i == 14) begin start = 1'b1; instrucao = ~b[7:4]; dado = ~b[3:0]; end
      if (i == 15) start = 1'b0;
      @(negedge clock);
    end
    tests++; if (pulses !== 1) begin failed++; $display("FAIL ign_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    int         pulses;
    pulses = 0;
    launch(8'h00);
    for (int i = 0; i < 17; i++) @(negedge clock);
    tests++; if (out !== 1'b0) begin failed++; $display("FAIL rst_pre_out: got %b want 0", out); end
    #2 reset = 1'b1;
    #1;
    tests++; if (out   !== 1'b1) begin failed++; $display("FAIL rst_async_out: got %b want 1", out); end
    tests++; if (ready !== 1'b1) begin failed++; $display("FAIL rst_async_ready: got %b want 1", ready); end
    for (int i = 0; i < 3; i++) begin
      if (done === 1'b1) pulses++;
      @(negedge clock);
    end
    b = 8'($urandom_range(0, 255));
    reset = 1'b0;
    instrucao = b[7:4]; dado = b[3:0]; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) pulses++;
      tests++; if (out !== model_bit(b, i)) begin failed++; $display("FAIL rst_frame_out cyc=%0d: got %b want %b", i, out, model_bit(b, i)); end
      @(negedge clock);
    end
    tests++; if (pulses !== 0) begin failed++; $display("FAIL rst_spurious_done: got %0d want 0", pulses); end
    tests++; if (done !== 1'b1) begin failed++; $display("FAIL rst_frame_done: got %b want 1", done); end
  endtask

  task automatic test_input_change();
    int ones;
    ones = 0;
    launch(8'hFF);
    instrucao = 4'h0; dado = 4'h0;
    for (int i = 0; i < 40; i++) begin
      tests++; if (out !== model_bit(8'hFF, i)) begin failed++; $display("FAIL chg_out cyc=%0d: got %b want %b", i, out, model_bit(8'hFF, i)); end
      if ((i % CPB) == 2 && i / CPB >= 1 && i / CPB <= 8 && out === 1'b1) ones++;
      @(negedge clock);
    end
    tests++; if (ones !== 8) begin failed++; $display("FAIL chg_ones: got %0d want 8", ones); end
  endtask

  task automatic test_two_stop();
    logic [7:0] b, rx;
    int         stop_hi;
    for (int n = 0; n < 2; n++) begin
      b = (n == 0) ? 8'h81 : 8'($urandom_range(0, 255));
      rx = 8'h00; stop_hi = 0;
      @(negedge clock);
      instrucao2 = b[7:4]; dado2 = b[3:0]; start2 = 1'b1;
      @(negedge clock);
      start2 = 1'b0;
      for (int i = 0; i < 44; i++) begin
        tests++; if (out2 !== model_bit(b, i)) begin failed++; $display("FAIL stop2_out b=%h cyc=%0d: got %b want %b", b, i, out2, model_bit(b, i)); end
        tests++; if (done2 !== 1'b0 || ready2 !== 1'b0) begin failed++; $display("FAIL stop2_busy b=%h cyc=%0d: got done=%b ready=%b want 0 0", b, i, done2, ready2); end
        if ((i % CPB) == 2 && i / CPB >= 1 && i / CPB <= 8) rx[i/CPB - 1] = out2;
        if (i >= 36 && out2 === 1'b1) stop_hi++;
        @(negedge clock);
      end
      tests++; if (done2 !== 1'b1 || ready2 !== 1'b1) begin failed++; $display("FAIL stop2_end b=%h: got done=%b ready=%b want 1 1", b, done2, ready2); end
      tests++; if (stop_hi !== 8) begin failed++; $display("FAIL stop2_len b=%h: got %0d want 8", b, stop_hi); end
      tests++; if (rx[7:4] !== b[7:4]) begin failed++; $display("FAIL loop_instr: got %h want %h", rx[7:4], b[7:4]); end
      tests++; if (rx[3:0] !== b[3:0]) begin failed++; $display("FAIL loop_data: got %h want %h", rx[3:0], b[3:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_ignore_start();
    test_reset_midframe();
    test_input_change();
    test_two_stop();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
